led_frame_streamer: RTL

Upstream feeder for the unipolar RZ line driver. Holds a double-buffered frame of NUM_LEDS RGB pixels written by a host and, on a show strobe, streams them word-by-word into the driver's data/enable/ready handshake. It then lets the driver emit its reset (latch) gap and reports frame completion. Frame buffers swap only at frame boundaries, so host writes never tear a frame in flight.

---
 rtl/led_stream_pkg.sv | 36 +++
 rtl/led_frame_buffer.sv | 50 +++++
 rtl/led_frame_streamer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/led_stream_pkg.sv
// Shared types and pixel helpers for the LED frame streamer.
// The driver shifts bit 0 first, so words go out as bit-reversed GRB.
package led_stream_pkg;

  localparam int COLOR_WIDTH = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    LATCH  = 2'd2
  } state_e;

  function automatic logic [COLOR_WIDTH-1:0] to_grb(rgb_t p);
    return {p.g, p.r, p.b};
  endfunction

  function automatic logic [23:0] bit_reverse24(logic [23:0] w);
    logic [23:0] r;
    for (int i = 0; i < 24; i++) r[i] = w[23-i];
    return r;
  endfunction

  // c' = (c * (k + 1)) >> 8, so k = 0xFF is identity
  function automatic logic [7:0] scale8(logic [7:0] c, logic [7:0] k);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, k} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel store: host writes the back buffer, streamer reads the front.
// rd_next_i reads the buffer that becomes front on this edge, with same-edge write forwarding.
module led_frame_buffer #(
  parameter int NUM_LEDS   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [23:0]           wr_data_i,
  input  logic                  swap_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_next_i,
  output logic [23:0]           rd_data_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH = NUM_LEDS[ADDR_WIDTH:0];

  logic [23:0] mem0_q [NUM_LEDS];
  logic [23:0] mem1_q [NUM_LEDS];
  logic        front_sel_q;
  logic        wr_ok;
  logic        rd_ok;

  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < DEPTH);
  assign rd_ok = {1'b0, rd_addr_i} < DEPTH;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) front_sel_q <= 1'b0;
    else if (swap_i) front_sel_q <= ~front_sel_q;
  end

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      if (front_sel_q) mem0_q[wr_addr_i] <= wr_data_i;
      else             mem1_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_ok) begin
      if (rd_next_i && wr_ok && (wr_addr_i == rd_addr_i)) rd_data_o = wr_data_i;
      else if (front_sel_q ^ rd_next_i)                 rd_data_o = mem1_q[rd_addr_i];
      else                                               rd_data_o = mem0_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/led_frame_streamer.sv
// Streams a double-buffered RGB frame into the RZ line driver, then waits out its latch gap.
// Optional global brightness scaling is enabled with `define LED_BRIGHTNESS_EN.
//
// state  | meaning
// IDLE   | no frame in flight, waiting for show
// STREAM | issuing one word per rz_ready edge until all pixels are sent
// LATCH  | last word accepted, waiting for the driver's reset gap to finish
module led_frame_streamer
  import led_stream_pkg::*;
#(
  parameter  int NUM_LEDS   = 8,
  parameter  int DATA_WIDTH = 24,
  localparam int ADDR_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  show,
  input  logic [7:0]            brightness,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] rz_data,
  output logic                  rz_enable,
  input  logic                  rz_ready
);

  localparam logic [ADDR_WIDTH:0] NUM_W = NUM_LEDS[ADDR_WIDTH:0];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   index_q, index_d;
  logic [DATA_WIDTH-1:0] rz_data_q, rz_data_d;
  logic                  rz_enable_q, rz_enable_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  pending_q, pending_d;
  logic                  swap;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_next;
  logic [23:0]           rd_data;
  logic [23:0]           word;

  led_frame_buffer #(
    .NUM_LEDS  (NUM_LEDS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_buf (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .swap_i   (swap),
    .rd_addr_i(rd_addr),
    .rd_next_i(rd_next),
    .rd_data_o(rd_data)
  );

`ifdef LED_BRIGHTNESS_EN
  // Prefetch the pixel for the next issue slot so the scaler gets a full cycle.
  rgb_t px_raw;
  rgb_t pix_q, pix_d;

  assign px_raw  = rd_data;
  assign rd_addr = index_d[ADDR_WIDTH-1:0];
  assign rd_next = swap;

  always_comb begin
    pix_d.r = scale8(px_raw.r, brightness);
    pix_d.g = scale8(px_raw.g, brightness);
    pix_d.b = scale8(px_raw.b, brightness);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pix_q <= '0;
    else          pix_q <= pix_d;
  end

  assign word = bit_reverse24(to_grb(pix_q));
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;
  assign rd_addr           = index_q[ADDR_WIDTH-1:0];
  assign rd_next           = 1'b0;
  assign word              = bit_reverse24(to_grb(rgb_t'(rd_data)));
`endif

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    rz_enable_d  = 1'b0;
    rz_data_d    = rz_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pending_d    = pending_q;
    swap         = 1'b0;

    if (show && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (show) begin
          swap    = 1'b1;
          index_d = '0;
          busy_d  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (rz_ready) begin
          if (index_q < NUM_W) begin
            rz_enable_d = 1'b1;
            rz_data_d   = word;
            index_d     = index_q + 1'b1;
          end else begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (rz_ready) begin
          frame_done_d = 1'b1;
          // A show arriving on this very edge still queues the next frame.
          if (pending_q || show) begin
            swap      = 1'b1;
            pending_d = 1'b0;
            index_d   = '0;
            state_d   = STREAM;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      index_q      <= '0;
      rz_data_q    <= '0;
      rz_enable_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      rz_data_q    <= rz_data_d;
      rz_enable_q  <= rz_enable_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
    end
  end

  assign rz_data    = rz_data_q;
  assign rz_enable  = rz_enable_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
